// File: rtl/generic_bus_sram_responder_if.sv
// Generic bus between a cpu-side requestor (master) and an SRAM responder (slave).
// Data width scales with BLOCK_SIZE 32-bit words per transfer.
interface generic_bus_sram_responder_if #(
  parameter int unsigned BLOCK_SIZE = 1
);
  logic [31:0]              addr;
  logic                     ren;
  logic                     wen;
  logic [32*BLOCK_SIZE-1:0] wdata;
  logic [3:0]               byte_en;
  logic [32*BLOCK_SIZE-1:0] rdata;
  logic                     busy;
  logic                     error;

  modport master (
    output addr, ren, wen, wdata, byte_en,
    input  rdata, busy, error
  );

  modport slave (
    input  addr, ren, wen, wdata, byte_en,
    output rdata, busy, error
  );
endinterface

// File: rtl/generic_bus_sram_responder.sv
// Word-addressed SRAM responder for the generic bus: programmable wait states,
// byte-enable block writes, and error responses for bad or conflicting requests.
module generic_bus_sram_responder #(
  parameter int unsigned BLOCK_SIZE  = 1,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic CLK,
  input logic RST,
  generic_bus_sram_responder_if.slave bus
);
  localparam int unsigned DW        = 32 * BLOCK_SIZE;
  localparam int unsigned IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] BLK_BYTES = 32'(4 * BLOCK_SIZE);
  localparam logic [3:0]  LAT       = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt;
  logic [31:0]     cap_addr;
  logic            cap_rd, cap_wr;
  logic [DW-1:0]   cap_wdata;
  logic [3:0]      cap_be;
  logic [DW-1:0]   rdata_q;
  logic            error_q;

  logic [31:0]     sel_addr, offset;
  logic            sel_rd, sel_wr;
  logic [DW-1:0]   sel_wdata;
  logic [3:0]      sel_be;
  logic            req_err, go_resp, commit_wr;
  logic [IW-1:0]   word_idx;
  logic [DW-1:0]   rd_block;

  logic [31:0]     mem [DEPTH_WORDS];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.ren || bus.wen) state_nx = (LAT == 4'd0) ? RESP : WAIT;
      WAIT: if (cnt <= 4'd1) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero latency RESP is entered on the capture edge itself, so the live
  // bus request is used there; otherwise the captured copy is authoritative.
  always_comb begin
    if (state == IDLE) begin
      sel_addr  = bus.addr;
      sel_rd    = bus.ren;
      sel_wr    = bus.wen;
      sel_wdata = bus.wdata;
      sel_be    = bus.byte_en;
    end else begin
      sel_addr  = cap_addr;
      sel_rd    = cap_rd;
      sel_wr    = cap_wr;
      sel_wdata = cap_wdata;
      sel_be    = cap_be;
    end
  end

  assign offset    = sel_addr - BASE_ADDR;
  assign req_err   = (sel_rd && sel_wr) || (sel_addr[1:0] != 2'b00) ||
                     ((offset % BLK_BYTES) != 32'd0) || (offset >= SPAN);
  assign word_idx  = offset[IW+1:2];
  assign go_resp   = (state_nx == RESP);
  assign commit_wr = go_resp && sel_wr && !req_err && !RST;

  always_comb begin
    rd_block = '0;
    for (int unsigned i = 0; i < BLOCK_SIZE; i++)
      rd_block[32*i +: 32] = mem[word_idx + IW'(i)];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_rd    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.ren || bus.wen) begin
          cap_addr  <= bus.addr;
          cap_rd    <= bus.ren;
          cap_wr    <= bus.wen;
          cap_wdata <= bus.wdata;
          cap_be    <= bus.byte_en;
          cnt       <= LAT;
        end
        WAIT: cnt <= cnt - 4'd1;
        default: ;
      endcase
      if (go_resp) begin
        error_q <= req_err;
        rdata_q <= (req_err || sel_wr) ? '0 : rd_block;
      end else begin
        error_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (commit_wr) begin
      for (int unsigned i = 0; i < BLOCK_SIZE; i++)
        for (int unsigned b = 0; b < 4; b++)
          if (sel_be[b]) mem[word_idx + IW'(i)][8*b +: 8] <= sel_wdata[32*i + 8*b +: 8];
    end
  end

  assign bus.busy  = (state != RESP);
  assign bus.error = error_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_generic_bus_sram_responder.sv
// Directed bench for generic_bus_sram_responder across four parameterisations:
// LATENCY 2 / 0 / 5 with single words, and a 4-word block responder at LATENCY 1.
module tb_generic_bus_sram_responder;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   stray = 0;

  always #5 CLK = ~CLK;

  generic_bus_sram_responder_if #(.BLOCK_SIZE(1)) bus_a ();
  generic_bus_sram_responder_if #(.BLOCK_SIZE(1)) bus_z ();
  generic_bus_sram_responder_if #(.BLOCK_SIZE(1)) bus_r ();
  generic_bus_sram_responder_if #(.BLOCK_SIZE(4)) bus_b ();

  generic_bus_sram_responder #(.BLOCK_SIZE(1), .DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0))
    dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
  generic_bus_sram_responder #(.BLOCK_SIZE(1), .DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0))
    dut_z (.CLK(CLK), .RST(RST), .bus(bus_z));
  generic_bus_sram_responder #(.BLOCK_SIZE(1), .DEPTH_WORDS(1024), .LATENCY(5), .BASE_ADDR(32'h0))
    dut_r (.CLK(CLK), .RST(RST), .bus(bus_r));
  generic_bus_sram_responder #(.BLOCK_SIZE(4), .DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0))
    dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

  logic         obs_busy  [4];
  logic         obs_err   [4];
  logic [127:0] obs_rdata [4];

  assign obs_busy[0] = bus_a.busy;  assign obs_err[0] = bus_a.error;  assign obs_rdata[0] = 128'(bus_a.rdata);
  assign obs_busy[1] = bus_z.busy;  assign obs_err[1] = bus_z.error;  assign obs_rdata[1] = 128'(bus_z.rdata);
  assign obs_busy[2] = bus_r.busy;  assign obs_err[2] = bus_r.error;  assign obs_rdata[2] = 128'(bus_r.rdata);
  assign obs_busy[3] = bus_b.busy;  assign obs_err[3] = bus_b.error;  assign obs_rdata[3] = bus_b.rdata;

  // error must never be seen while busy is high
  always @(negedge CLK)
    if (!RST)
      for (int i = 0; i < 4; i++)
        if (obs_busy[i] && obs_err[i]) stray++;

  task automatic drive(input int w, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [127:0] wd, input logic [3:0] be);
    case (w)
      0: begin bus_a.ren = rd; bus_a.wen = wr; bus_a.addr = a; bus_a.wdata = wd[31:0]; bus_a.byte_en = be; end
      1: begin bus_z.ren = rd; bus_z.wen = wr; bus_z.addr = a; bus_z.wdata = wd[31:0]; bus_z.byte_en = be; end
      2: begin bus_r.ren = rd; bus_r.wen = wr; bus_r.addr = a; bus_r.wdata = wd[31:0]; bus_r.byte_en = be; end
      default: begin bus_b.ren = rd; bus_b.wen = wr; bus_b.addr = a; bus_b.wdata = wd; bus_b.byte_en = be; end
    endcase
  endtask

  // One transaction; cyc = cycles from the capture edge until busy is seen low (99 on timeout)
  task automatic acc(input int w, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [127:0] wd, input logic [3:0] be,
                     output logic [127:0] rdat, output logic err, output int cyc);
    bit done = 0;
    @(negedge CLK);
    drive(w, rd, wr, a, wd, be);
    cyc = 99;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge CLK);
      if (!obs_busy[w]) begin
        cyc = i;
        done = 1;
      end
    end
    rdat = obs_rdata[w];
    err  = obs_err[w];
    drive(w, 1'b0, 1'b0, 32'h0, 128'h0, 4'h0);
  endtask

  task automatic test_reset();
    for (int w = 0; w < 4; w++) drive(w, 1'b0, 1'b0, 32'h0, 128'h0, 4'h0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    for (int w = 0; w < 4; w++) begin
      total++;
      if (obs_busy[w] !== 1'b1 || obs_err[w] !== 1'b0 || obs_rdata[w] !== 128'h0) begin
        bad++;
        $display("FAIL reset_state dut%0d: busy=%b error=%b rdata=%h want busy=1 error=0 rdata=0",
                 w, obs_busy[w], obs_err[w], obs_rdata[w]);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_write_read();
    logic [127:0] r; logic e; int c;
    acc(0, 1'b0, 1'b1, 32'h10, 128'hDEAD_BEEF, 4'hF, r, e, c);
    total++; if (c !== 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", c); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_error: got %b want 0", e); end
    acc(0, 1'b1, 1'b0, 32'h10, 128'h0, 4'hF, r, e, c);
    total++; if (c !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", c); end
    total++; if (r[31:0] !== 32'hDEAD_BEEF || e !== 1'b0) begin
      bad++; $display("FAIL rd_after_wr: got %h err=%b want deadbeef err=0", r[31:0], e);
    end
  endtask

  task automatic test_byte_enable();
    logic [127:0] r; logic e; int c;
    acc(0, 1'b0, 1'b1, 32'h20, 128'h1122_3344, 4'hF, r, e, c);
    acc(0, 1'b0, 1'b1, 32'h20, 128'hAABB_CCDD, 4'b0101, r, e, c);
    acc(0, 1'b1, 1'b0, 32'h20, 128'h0, 4'hF, r, e, c);
    total++; if (r[31:0] !== 32'h11BB_33DD) begin
      bad++; $display("FAIL byte_en_merge: got %h want 11bb33dd", r[31:0]);
    end
    acc(0, 1'b0, 1'b1, 32'h20, 128'hFFFF_FFFF, 4'b0000, r, e, c);
    total++; if (e !== 1'b0 || c !== 3) begin
      bad++; $display("FAIL byte_en_zero_resp: err=%b cyc=%0d want err=0 cyc=3", e, c);
    end
    acc(0, 1'b1, 1'b0, 32'h20, 128'h0, 4'hF, r, e, c);
    total++; if (r[31:0] !== 32'h11BB_33DD) begin
      bad++; $display("FAIL byte_en_zero_keep: got %h want 11bb33dd", r[31:0]);
    end
  endtask

  task automatic test_errors();
    logic [127:0] r; logic e; int c;
    acc(0, 1'b0, 1'b1, 32'h0, 128'h0BAD_F00D, 4'hF, r, e, c);
    acc(0, 1'b1, 1'b0, 32'h1002, 128'h0, 4'hF, r, e, c);
    total++; if (e !== 1'b1 || r !== 128'h0 || c !== 3) begin
      bad++; $display("FAIL err_misaligned: err=%b rdata=%h cyc=%0d want err=1 rdata=0 cyc=3", e, r, c);
    end
    acc(0, 1'b0, 1'b1, 32'h1000, 128'hFFFF_FFFF, 4'hF, r, e, c);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL err_out_of_range: got %b want 1", e); end
    acc(0, 1'b1, 1'b0, 32'h0, 128'h0, 4'hF, r, e, c);
    total++; if (r[31:0] !== 32'h0BAD_F00D || e !== 1'b0) begin
      bad++; $display("FAIL err_no_write: got %h err=%b want 0badf00d err=0", r[31:0], e);
    end
    acc(0, 1'b1, 1'b1, 32'h0, 128'h1234, 4'hF, r, e, c);
    total++; if (e !== 1'b1 || r !== 128'h0) begin
      bad++; $display("FAIL err_rd_wr_conflict: err=%b rdata=%h want err=1 rdata=0", e, r);
    end
    acc(0, 1'b1, 1'b0, 32'h0, 128'h0, 4'hF, r, e, c);
    total++; if (r[31:0] !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL err_conflict_no_write: got %h want 0badf00d", r[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] r; logic e; int c;
    for (int i = 0; i < 4; i++) begin
      acc(1, 1'b0, 1'b1, 32'h100 + 32'(4*i), 128'hC0DE_0000 + 128'(i), 4'hF, r, e, c);
      total++; if (c !== 1) begin bad++; $display("FAIL lat0_wr_latency %0d: got %0d want 1", i, c); end
    end
    @(negedge CLK);
    drive(1, 1'b1, 1'b0, 32'h100, 128'h0, 4'hF);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      total++;
      if (obs_busy[1] !== ((k % 2) == 1)) begin
        bad++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, obs_busy[1], (k % 2) == 1);
      end
      if ((k % 2) == 0) begin
        total++;
        if (obs_rdata[1][31:0] !== 32'hC0DE_0000 + 32'(k/2)) begin
          bad++; $display("FAIL b2b_rdata k=%0d: got %h want %h", k, obs_rdata[1][31:0], 32'hC0DE_0000 + 32'(k/2));
        end
        if (k == 6) drive(1, 1'b0, 1'b0, 32'h0, 128'h0, 4'h0);
        else        drive(1, 1'b1, 1'b0, 32'h100 + 32'(4*(k/2+1)), 128'h0, 4'hF);
      end
    end
  endtask

  task automatic test_block();
    logic [127:0] r; logic e; int c;
    logic [127:0] blk = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    acc(3, 1'b0, 1'b1, 32'h40, blk, 4'hF, r, e, c);
    total++; if (c !== 2 || e !== 1'b0) begin
      bad++; $display("FAIL blk_write: cyc=%0d err=%b want cyc=2 err=0", c, e);
    end
    acc(3, 1'b1, 1'b0, 32'h40, 128'h0, 4'hF, r, e, c);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (r[32*i +: 32] !== blk[32*i +: 32]) begin
        bad++; $display("FAIL blk_word%0d: got %h want %h", i, r[32*i +: 32], blk[32*i +: 32]);
      end
    end
    acc(3, 1'b1, 1'b0, 32'h44, 128'h0, 4'hF, r, e, c);
    total++; if (e !== 1'b1 || r !== 128'h0) begin
      bad++; $display("FAIL blk_unaligned: err=%b rdata=%h want err=1 rdata=0", e, r);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [127:0] r; logic e; int c;
    acc(2, 1'b0, 1'b1, 32'h30, 128'h1234_5678, 4'hF, r, e, c);
    total++; if (c !== 6) begin bad++; $display("FAIL lat5_latency: got %0d want 6", c); end
    acc(2, 1'b1, 1'b0, 32'h30, 128'h0, 4'hF, r, e, c);
    total++; if (r[31:0] !== 32'h1234_5678) begin
      bad++; $display("FAIL lat5_read: got %h want 12345678", r[31:0]);
    end
    @(negedge CLK);
    drive(2, 1'b0, 1'b1, 32'h30, 128'hFFFF_0000, 4'hF);
    repeat (3) @(negedge CLK);
    total++; if (obs_busy[2] !== 1'b1) begin bad++; $display("FAIL mid_wait_busy: got %b want 1", obs_busy[2]); end
    RST = 1'b1;
    #1;
    total++; if (obs_busy[2] !== 1'b1 || obs_err[2] !== 1'b0 || obs_rdata[2] !== 128'h0) begin
      bad++; $display("FAIL rst_mid_wait: busy=%b err=%b rdata=%h want 1 0 0", obs_busy[2], obs_err[2], obs_rdata[2]);
    end
    drive(2, 1'b0, 1'b0, 32'h0, 128'h0, 4'h0);
    @(negedge CLK);
    RST = 1'b0;
    acc(2, 1'b1, 1'b0, 32'h30, 128'h0, 4'hF, r, e, c);
    total++; if (r[31:0] !== 32'h1234_5678 || e !== 1'b0) begin
      bad++; $display("FAIL rst_drop_write: got %h err=%b want 12345678 err=0", r[31:0], e);
    end
  endtask

  task automatic test_error_quiet();
    total++;
    if (stray !== 0) begin bad++; $display("FAIL error_while_busy: got %0d cycles want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_block();
    test_reset_mid_wait();
    test_error_quiet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
